// File: rtl/lif_stdp_neuron.sv
// Leaky integrate-and-fire neuron with refractory period, saturating arithmetic,
// trace-based STDP (LTP always, LTD when STDP_DEPRESS_EN is defined) and a host weight-write port.
module lif_stdp_neuron #(
  parameter int N_IN      = 4,
  parameter int W_WIDTH   = 8,
  parameter int V_WIDTH   = 12,
  parameter int V_THRESH  = 100,
  parameter int V_RESET   = 0,
  parameter int LEAK      = 2,
  parameter int REFRAC    = 3,
  parameter int T_WIDTH   = 4,
  parameter int TRACE_WIN = 5,
  parameter int ETA_P     = 1,
  parameter int ETA_D     = 1,
  parameter int W_INIT    = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           x,
  input  logic                      learn_en,
  input  logic                      wr_en,
  input  logic [3:0]                wr_idx,
  input  logic [W_WIDTH-1:0]        wr_data,
  output logic                      spike_out,
  output logic                      refractory,
  output logic [V_WIDTH-1:0]        v_mem,
  output logic [N_IN*W_WIDTH-1:0]   weights
);

  // Accumulator is wide enough for v_mem plus 16 full-scale weights, so it never wraps.
  localparam int S_WIDTH = V_WIDTH + W_WIDTH + 5;
  localparam int C_WIDTH = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [V_WIDTH-1:0] V_MAX_L    = '1;
  localparam logic [V_WIDTH-1:0] LEAK_L     = V_WIDTH'(LEAK);
  localparam logic [V_WIDTH-1:0] THRESH_L   = V_WIDTH'(V_THRESH);
  localparam logic [V_WIDTH-1:0] V_RESET_L  = V_WIDTH'(V_RESET);
  localparam logic [W_WIDTH-1:0] W_MAX_L    = '1;
  localparam logic [W_WIDTH-1:0] W_INIT_L   = W_WIDTH'(W_INIT);
  localparam logic [T_WIDTH-1:0] TRACE_L    = T_WIDTH'(TRACE_WIN);

  logic [W_WIDTH-1:0] w_q    [N_IN];
  logic [W_WIDTH-1:0] w_next [N_IN];
  logic [T_WIDTH-1:0] pre_q  [N_IN];
  logic [T_WIDTH-1:0] post_q;
  logic [C_WIDTH-1:0] cnt_q;

  logic [S_WIDTH-1:0] sum;
  logic [V_WIDTH-1:0] sat_v;
  logic [V_WIDTH-1:0] n_v;
  logic               fire;
  logic [W_WIDTH:0]   ltp_w;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum = S_WIDTH'(v_mem);
    for (int i = 0; i < N_IN; i++) begin
      if (x[i]) sum = sum + S_WIDTH'(w_q[i]);
    end
    sat_v = (sum > S_WIDTH'(V_MAX_L)) ? V_MAX_L : sum[V_WIDTH-1:0];
    n_v   = (sat_v > LEAK_L) ? sat_v - LEAK_L : '0;
    fire  = (cnt_q == '0) && (n_v >= THRESH_L);
  end

  always_comb begin
    ltp_w = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_next[i] = w_q[i];
      ltp_w     = {1'b0, w_q[i]} + (W_WIDTH+1)'(ETA_P);
      if (learn_en && fire && (x[i] || pre_q[i] != '0)) begin
        w_next[i] = (ltp_w > {1'b0, W_MAX_L}) ? W_MAX_L : ltp_w[W_WIDTH-1:0];
      end
`ifdef STDP_DEPRESS_EN
      // Depression only outside fire cycles, so it never competes with LTP.
      if (learn_en && !fire && x[i] && post_q != '0) begin
        w_next[i] = (w_q[i] > W_WIDTH'(ETA_D)) ? w_q[i] - W_WIDTH'(ETA_D) : '0;
      end
`endif
      if (wr_en && wr_idx == 4'(i)) w_next[i] = wr_data;
    end
  end

  always_comb begin
    weights = '0;
    for (int i = 0; i < N_IN; i++) weights[i*W_WIDTH +: W_WIDTH] = w_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_mem      <= V_RESET_L;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
      cnt_q      <= '0;
      post_q     <= '0;
      // NOTE: the weight/trace arrays are reset explicitly; a known W_INIT start is functional state.
      for (int i = 0; i < N_IN; i++) begin
        w_q[i]   <= W_INIT_L;
        pre_q[i] <= '0;
      end
    end else begin
      spike_out <= fire;
      if (cnt_q != '0) begin
        v_mem      <= V_RESET_L;
        cnt_q      <= cnt_q - C_WIDTH'(1);
        refractory <= (cnt_q != C_WIDTH'(1));
      end else if (fire) begin
        v_mem      <= V_RESET_L;
        cnt_q      <= C_WIDTH'(REFRAC);
        refractory <= (REFRAC != 0);
      end else begin
        v_mem      <= n_v;
        refractory <= 1'b0;
      end

      post_q <= fire ? TRACE_L : ((post_q != '0) ? post_q - T_WIDTH'(1) : '0);
      for (int i = 0; i < N_IN; i++) begin
        w_q[i]   <= w_next[i];
        pre_q[i] <= x[i] ? TRACE_L : ((pre_q[i] != '0) ? pre_q[i] - T_WIDTH'(1) : '0);
      end
    end
  end

endmodule
